softmax_max_sub: RTL and testbench

//   Max-subtraction stage of the Softmax datapath. It buffers one vector of VEC_LEN signed

---
 rtl/softmax_max_sub.sv | 137 +++++++++++++
 tb/tb_softmax_max_sub.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_max_sub.sv
// Softmax max-subtraction stage: buffers one vector, tracks its running maximum,
// then streams each element minus that maximum through a valid/ready output.
module softmax_max_sub #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   out_data,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] max_val,
    output logic                  busy
);

    localparam int ADDR_W = $clog2(VEC_LEN);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(VEC_LEN - 1);

    typedef enum logic {S_LOAD, S_EMIT} state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     wr_idx_q, wr_idx_d;
    logic [ADDR_W-1:0]     rd_idx_q, rd_idx_d;
    logic [DATA_WIDTH-1:0] run_max_q, run_max_d;
    logic [DATA_WIDTH-1:0] max_val_q, max_val_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH:0]   out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic                  in_ready_q, in_ready_d;
    logic [DATA_WIDTH-1:0] buf_q [VEC_LEN];

    logic                  accept;
    logic                  transfer;
    logic [DATA_WIDTH-1:0] new_max;
    logic [ADDR_W-1:0]     rd_next;

    // Both operands sign-extended by one bit, so the difference never overflows.
    function automatic logic [DATA_WIDTH:0] sub_ext(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
        return {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
    endfunction

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        run_max_d   = run_max_q;
        max_val_d   = max_val_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        accept   = in_valid & in_ready_q;
        transfer = out_valid_q & out_ready;
        rd_next  = rd_idx_q + 1'b1;
        new_max  = ((wr_idx_q == '0) || ($signed(in_data) > $signed(run_max_q)))
                   ? in_data : run_max_q;

        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    run_max_d = new_max;
                    if (wr_idx_q == LAST_IDX) begin
                        // Element 0 is already buffered, so the first output is registered here.
                        wr_idx_d    = '0;
                        rd_idx_d    = '0;
                        max_val_d   = new_max;
                        out_valid_d = 1'b1;
                        out_data_d  = sub_ext(buf_q[0], new_max);
                        out_last_d  = 1'b0;
                        state_d     = S_EMIT;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (transfer) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        rd_idx_d    = '0;
                        state_d     = S_LOAD;
                    end else begin
                        rd_idx_d   = rd_next;
                        out_data_d = sub_ext(buf_q[rd_next], max_val_q);
                        out_last_d = (rd_next == LAST_IDX);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase

        in_ready_d = (state_d == S_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            run_max_q   <= '0;
            max_val_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            run_max_q   <= run_max_d;
            max_val_q   <= max_val_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q[wr_idx_q] <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign max_val   = max_val_q;
    assign busy      = (state_q == S_EMIT);

endmodule

// File: tb/tb_softmax_max_sub.sv
// Scoreboard bench for softmax_max_sub with DATA_WIDTH=8, VEC_LEN=4.
module tb_softmax_max_sub;

    localparam int DW = 8;
    localparam int VL = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [DW-1:0]        in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [DW:0]   out_data;
    logic                 out_last;
    logic signed [DW-1:0] max_val;
    logic                 busy;

    softmax_max_sub #(.DATA_WIDTH(DW), .VEC_LEN(VL)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .max_val(max_val), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [DW:0]   d;
        logic                 last;
        logic signed [DW-1:0] mx;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int fails  = 0;

    logic signed [DW-1:0] vec [VL];
    logic signed [DW:0]   got_d [VL];
    logic                 got_last [VL];
    logic signed [DW-1:0] got_mx [VL];
    int n_got, first_cyc, hold_err, ir_err;

    // Drives cnt elements of vec; a full vector also pushes its expected outputs.
    task automatic load_vec(input int cnt, input bit gaps);
        logic signed [DW-1:0] m;
        exp_t e;
        int t;
        m = vec[0];
        for (int i = 1; i < VL; i++) if (vec[i] > m) m = vec[i];
        if (cnt == VL) begin
            for (int i = 0; i < VL; i++) begin
                e.d = $signed(vec[i]) - $signed(m);
                e.last = (i == VL - 1);
                e.mx = m;
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < cnt; i++) begin
            if (gaps && (i % 2 == 1)) begin
                in_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = vec[i];
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                checks++; fails++;
                $display("FAIL load_timeout elem %0d: in_ready=%0b, required 1", i, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Collects up to VL output transfers; records stall/hold and in_ready observations.
    task automatic drain(input bit toggle);
        logic signed [DW:0] pd;
        logic pl;
        bit have_prev;
        n_got = 0; first_cyc = -1; hold_err = 0; ir_err = 0; have_prev = 0;
        pd = '0; pl = 1'b0;
        for (int cyc = 0; cyc < 64 && n_got < VL; cyc++) begin
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            if (have_prev && (out_data !== pd || out_last !== pl)) hold_err++;
            have_prev = 0;
            if (in_ready) ir_err++;
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (out_valid && out_ready) begin
                got_d[n_got] = out_data;
                got_last[n_got] = out_last;
                got_mx[n_got] = max_val;
                n_got++;
            end else if (out_valid) begin
                pd = out_data; pl = out_last; have_prev = 1;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #7;
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %0b need 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %0b need 0", out_valid); end
        checks++; if (out_data !== 9'sd0) begin fails++; $display("FAIL rst_out_data got %0d need 0", out_data); end
        checks++; if (out_last !== 1'b0) begin fails++; $display("FAIL rst_out_last got %0b need 0", out_last); end
        checks++; if (max_val !== 8'sd0) begin fails++; $display("FAIL rst_max_val got %0d need 0", max_val); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %0b need 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        exp_t e;
        vec = '{12, 6, 1, -3};
        load_vec(VL, 0);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL t1_busy got %0b need 1", busy); end
        drain(0);
        checks++; if (first_cyc !== 0) begin fails++; $display("FAIL t1_latency got %0d need 0", first_cyc); end
        checks++; if (n_got !== VL) begin fails++; $display("FAIL t1_count got %0d need %0d", n_got, VL); end
        for (int i = 0; i < n_got; i++) begin
            e = exp_q.pop_front();
            checks++; if (got_d[i] !== e.d) begin fails++; $display("FAIL t1_data[%0d] got %0d need %0d", i, got_d[i], e.d); end
            checks++; if (got_last[i] !== e.last) begin fails++; $display("FAIL t1_last[%0d] got %0b need %0b", i, got_last[i], e.last); end
            checks++; if (got_mx[i] !== e.mx) begin fails++; $display("FAIL t1_max[%0d] got %0d need %0d", i, got_mx[i], e.mx); end
        end
        exp_q.delete();
        checks++; if (ir_err !== 0) begin fails++; $display("FAIL t1_in_ready_emit got %0d highs need 0", ir_err); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL t1_in_ready_after got %0b need 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t1_valid_after got %0b need 0", out_valid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL t1_busy_after got %0b need 0", busy); end
        checks++; if (max_val !== 8'sd12) begin fails++; $display("FAIL t1_max_held got %0d need 12", max_val); end
        @(posedge clk); #1;
    endtask

    task automatic test_negative;
        exp_t e;
        vec = '{-3, 5, 5, -128};
        load_vec(VL, 0);
        drain(0);
        checks++; if (n_got !== VL) begin fails++; $display("FAIL t2_count got %0d need %0d", n_got, VL); end
        for (int i = 0; i < n_got; i++) begin
            e = exp_q.pop_front();
            checks++; if (got_d[i] !== e.d) begin fails++; $display("FAIL t2_data[%0d] got %0d need %0d", i, got_d[i], e.d); end
            checks++; if (got_last[i] !== e.last) begin fails++; $display("FAIL t2_last[%0d] got %0b need %0b", i, got_last[i], e.last); end
            checks++; if (got_mx[i] !== e.mx) begin fails++; $display("FAIL t2_max[%0d] got %0d need %0d", i, got_mx[i], e.mx); end
        end
        exp_q.delete();
    endtask

    task automatic test_all_min;
        exp_t e;
        vec = '{-128, -128, -128, -128};
        load_vec(VL, 0);
        drain(0);
        checks++; if (n_got !== VL) begin fails++; $display("FAIL t3_count got %0d need %0d", n_got, VL); end
        for (int i = 0; i < n_got; i++) begin
            e = exp_q.pop_front();
            checks++; if (got_d[i] !== e.d) begin fails++; $display("FAIL t3_data[%0d] got %0d need %0d", i, got_d[i], e.d); end
            checks++; if (got_mx[i] !== e.mx) begin fails++; $display("FAIL t3_max[%0d] got %0d need %0d", i, got_mx[i], e.mx); end
        end
        exp_q.delete();
    endtask

    task automatic test_stall;
        exp_t e;
        vec = '{1, 6, -3, 5};
        load_vec(VL, 1);
        drain(1);
        checks++; if (n_got !== VL) begin fails++; $display("FAIL t4_count got %0d need %0d", n_got, VL); end
        for (int i = 0; i < n_got; i++) begin
            e = exp_q.pop_front();
            checks++; if (got_d[i] !== e.d) begin fails++; $display("FAIL t4_data[%0d] got %0d need %0d", i, got_d[i], e.d); end
            checks++; if (got_last[i] !== e.last) begin fails++; $display("FAIL t4_last[%0d] got %0b need %0b", i, got_last[i], e.last); end
        end
        exp_q.delete();
        checks++; if (hold_err !== 0) begin fails++; $display("FAIL t4_hold got %0d changes need 0", hold_err); end
        checks++; if (ir_err !== 0) begin fails++; $display("FAIL t4_in_ready_emit got %0d highs need 0", ir_err); end
    endtask

    task automatic test_mid_reset;
        exp_t e;
        int stale;
        vec = '{3, 9, 0, 0};
        load_vec(2, 0);
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL t5_rst_in_ready got %0b need 0", in_ready); end
        checks++; if (max_val !== 8'sd0) begin fails++; $display("FAIL t5_rst_max got %0d need 0", max_val); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t5_rst_valid got %0b need 0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++; if (stale !== 0) begin fails++; $display("FAIL t5_stale got %0d valid cycles need 0", stale); end
        @(posedge clk); #1;
        vec = '{7, 0, 0, 0};
        load_vec(VL, 0);
        drain(0);
        checks++; if (n_got !== VL) begin fails++; $display("FAIL t5_count got %0d need %0d", n_got, VL); end
        for (int i = 0; i < n_got; i++) begin
            e = exp_q.pop_front();
            checks++; if (got_d[i] !== e.d) begin fails++; $display("FAIL t5_data[%0d] got %0d need %0d", i, got_d[i], e.d); end
            checks++; if (got_mx[i] !== e.mx) begin fails++; $display("FAIL t5_max[%0d] got %0d need %0d", i, got_mx[i], e.mx); end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back;
        exp_t e;
        vec = '{50, 10, 20, 30};
        load_vec(VL, 0);
        in_valid = 1'b1;
        in_data  = 8'hEC;
        drain(0);
        checks++; if (ir_err !== 0) begin fails++; $display("FAIL t6_in_ready_emit got %0d highs need 0", ir_err); end
        checks++; if (n_got !== VL) begin fails++; $display("FAIL t6a_count got %0d need %0d", n_got, VL); end
        for (int i = 0; i < n_got; i++) begin
            e = exp_q.pop_front();
            checks++; if (got_d[i] !== e.d) begin fails++; $display("FAIL t6a_data[%0d] got %0d need %0d", i, got_d[i], e.d); end
        end
        exp_q.delete();
        vec = '{-20, -30, -40, -50};
        load_vec(VL, 0);
        drain(0);
        checks++; if (n_got !== VL) begin fails++; $display("FAIL t6b_count got %0d need %0d", n_got, VL); end
        for (int i = 0; i < n_got; i++) begin
            e = exp_q.pop_front();
            checks++; if (got_d[i] !== e.d) begin fails++; $display("FAIL t6b_data[%0d] got %0d need %0d", i, got_d[i], e.d); end
            checks++; if (got_last[i] !== e.last) begin fails++; $display("FAIL t6b_last[%0d] got %0b need %0b", i, got_last[i], e.last); end
            checks++; if (got_mx[i] !== e.mx) begin fails++; $display("FAIL t6b_max[%0d] got %0d need %0d", i, got_mx[i], e.mx); end
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_all_min();
        test_stall();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
